sd_cmd_rx: RTL

SD_CMD_RX -- requirements
Module: sd_cmd_rx

---
 rtl/sd_cmd_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sd_cmd_rx.sv
// SD CMD line response receiver: catches one 48-bit response frame after a start
// request, checks framing and CRC7, and reports index/argument or a timeout.
module sd_cmd_rx #(
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_sample,
    input  logic        i_sd_cmd,
    input  logic        i_start,
    input  logic        i_ignore_crc,
    output logic        o_busy,
    output logic        o_done,
    output logic [5:0]  o_index,
    output logic [31:0] o_arg,
    output logic        o_crc_error,
    output logic        o_frame_error,
    output logic        o_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [TW-1:0] to_cnt;
    logic [5:0]  bit_cnt;   // bits of the frame taken so far
    logic [6:0]  crc;
    logic [45:0] shreg;     // after 47 bits: frame bits 46..1, bit 1 at [0]
    logic        ign;
    logic        to_hit;
    logic        last_bit;

    // CRC7, polynomial x^7 + x^3 + 1, one bit per call
    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic inv;
        inv = c[6] ^ b;
        return {c[5:3], c[2] ^ inv, c[1:0], inv};
    endfunction

    assign to_hit   = i_sample && i_sd_cmd && (to_cnt == TW'(TIMEOUT - 1));
    assign last_bit = i_sample && (bit_cnt == 6'd47);
    assign o_busy   = (state == WAIT_START) || (state == RECEIVE);
    assign o_done   = (state == DONE);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (i_start) state_nxt = WAIT_START;
            WAIT_START: if (i_sample) begin
                            if (!i_sd_cmd)  state_nxt = RECEIVE;
                            else if (to_hit) state_nxt = DONE;
                        end
            RECEIVE:    if (last_bit) state_nxt = DONE;
            DONE:       state_nxt = IDLE;
        endcase
    end

    // Counters, shift register, CRC and result registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            to_cnt        <= '0;
            bit_cnt       <= '0;
            crc           <= '0;
            shreg         <= '0;
            ign           <= 1'b0;
            o_index       <= '0;
            o_arg         <= '0;
            o_crc_error   <= 1'b0;
            o_frame_error <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (i_start) begin
                    to_cnt  <= '0;
                    bit_cnt <= '0;
                    crc     <= '0;
                    ign     <= i_ignore_crc;
                end
                WAIT_START: if (i_sample) begin
                    if (!i_sd_cmd) begin
                        crc     <= crc7_next(crc, 1'b0);
                        shreg   <= {shreg[44:0], 1'b0};
                        bit_cnt <= 6'd1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                        // results of the timeout land in the DONE cycle
                        if (to_hit) begin
                            o_timeout     <= 1'b1;
                            o_crc_error   <= 1'b0;
                            o_frame_error <= 1'b0;
                        end
                    end
                end
                RECEIVE: if (i_sample) begin
                    shreg   <= {shreg[44:0], i_sd_cmd};
                    bit_cnt <= bit_cnt + 6'd1;
                    // CRC covers frame bits 47..8, i.e. the first 40 bits taken
                    if (bit_cnt < 6'd40) crc <= crc7_next(crc, i_sd_cmd);
                    // end bit: publish the frame so it is visible with o_done
                    if (bit_cnt == 6'd47) begin
                        o_index       <= shreg[44:39];
                        o_arg         <= shreg[38:7];
                        o_frame_error <= shreg[45] || !i_sd_cmd;
                        o_crc_error   <= (shreg[6:0] != crc) && !ign;
                        o_timeout     <= 1'b0;
                    end
                end
                DONE: ;
            endcase
        end
    end

endmodule
